// File: rtl/mul_hilo_sequencer_if.sv
// Bus bundle between the multiply sequencer, its requester, the Booth
// multiplier operand/product lines and the HI/LO writeback port.
interface mul_hilo_sequencer_if;
   logic               start;
   logic signed [31:0] a_in;
   logic signed [31:0] b_in;
   logic signed [31:0] mul_mcnd;
   logic signed [31:0] mul_mplr;
   logic signed [63:0] mul_y;
   logic               busy;
   logic [31:0]        wb_data;
   logic               lo_wr;
   logic               hi_wr;
   logic               done;
   logic [31:0]        zhi;
   logic [31:0]        zlo;

   modport slave (
      input  start, a_in, b_in, mul_y,
      output mul_mcnd, mul_mplr, busy, wb_data, lo_wr, hi_wr, done, zhi, zlo
   );

   modport master (
      output start, a_in, b_in, mul_y,
      input  mul_mcnd, mul_mplr, busy, wb_data, lo_wr, hi_wr, done, zhi, zlo
   );
endinterface

// File: rtl/mul_hilo_sequencer.sv
// Sequences one multiply through the external Booth multiplier: holds the
// operands, waits out its latency, captures ZHI/ZLO and writes LO then HI.
module mul_hilo_sequencer #(
   parameter int MUL_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   mul_hilo_sequencer_if.slave    bus
);

   localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_WB_LO = 2'd2,
      S_WB_HI = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic signed [31:0] mcnd_q, mcnd_d;
   logic signed [31:0] mplr_q, mplr_d;
   logic [31:0]        zhi_q, zhi_d;
   logic [31:0]        zlo_q, zlo_d;
   logic               busy_q, busy_d;
   logic               lo_wr_q, lo_wr_d;
   logic               hi_wr_q, hi_wr_d;
   logic               done_q, done_d;
   logic [31:0]        wb_data_q, wb_data_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcnd_d  = mcnd_q;
      mplr_d  = mplr_q;
      zhi_d   = zhi_q;
      zlo_d   = zlo_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mcnd_d  = bus.a_in;
               mplr_d  = bus.b_in;
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // One extra cycle at cnt==0 covers the multiplier's output register.
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               zhi_d   = bus.mul_y[63:32];
               zlo_d   = bus.mul_y[31:0];
               state_d = S_WB_LO;
            end
         end
         S_WB_LO: state_d = S_WB_HI;
         S_WB_HI: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered decodes of the next state.
      busy_d    = (state_d != S_IDLE);
      lo_wr_d   = (state_d == S_WB_LO);
      hi_wr_d   = (state_d == S_WB_HI);
      done_d    = hi_wr_d;
      wb_data_d = lo_wr_d ? zlo_d : (hi_wr_d ? zhi_d : 32'd0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         mcnd_q    <= '0;
         mplr_q    <= '0;
         zhi_q     <= '0;
         zlo_q     <= '0;
         busy_q    <= 1'b0;
         lo_wr_q   <= 1'b0;
         hi_wr_q   <= 1'b0;
         done_q    <= 1'b0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcnd_q    <= mcnd_d;
         mplr_q    <= mplr_d;
         zhi_q     <= zhi_d;
         zlo_q     <= zlo_d;
         busy_q    <= busy_d;
         lo_wr_q   <= lo_wr_d;
         hi_wr_q   <= hi_wr_d;
         done_q    <= done_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign bus.mul_mcnd = mcnd_q;
   assign bus.mul_mplr = mplr_q;
   assign bus.zhi      = zhi_q;
   assign bus.zlo      = zlo_q;
   assign bus.busy     = busy_q;
   assign bus.lo_wr    = lo_wr_q;
   assign bus.hi_wr    = hi_wr_q;
   assign bus.done     = done_q;
   assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_mul_hilo_sequencer.sv
// Directed bench for mul_hilo_sequencer with a registered behavioural
// multiplier and a request-level reference model checked every cycle.
module tb_mul_hilo_sequencer;
   localparam int L = 1;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   mul_hilo_sequencer_if bus ();

   mul_hilo_sequencer #(.MUL_LATENCY(L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural Booth multiplier: registered full signed product.
   function automatic logic [63:0] sext(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   always @(posedge clk) bus.mul_y <= sext(bus.mul_mcnd) * sext(bus.mul_mplr);

   // Request-level model: one request in flight, aged in cycles since acceptance.
   logic               m_active;
   int                 m_age;
   logic [63:0]        m_prod;
   logic [63:0]        m_zprev;
   logic signed [31:0] m_a;
   logic signed [31:0] m_b;

   initial begin
      m_active = 1'b0; m_age = 0; m_prod = '0; m_zprev = '0; m_a = '0; m_b = '0;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active <= 1'b0;
         m_age    <= 0;
         m_prod   <= '0;
         m_zprev  <= '0;
         m_a      <= '0;
         m_b      <= '0;
      end else if (!m_active) begin
         if (bus.start) begin
            m_active <= 1'b1;
            m_age    <= 1;
            m_prod   <= sext(bus.a_in) * sext(bus.b_in);
            m_a      <= bus.a_in;
            m_b      <= bus.b_in;
         end
      end else if (m_age == 3 + L) begin
         m_active <= 1'b0;
         m_zprev  <= m_prod;
      end else begin
         m_age <= m_age + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   logic        e_lo, e_hi;
   logic [63:0] e_z;

   always @(negedge clk) begin
      e_lo = m_active && (m_age == 2 + L);
      e_hi = m_active && (m_age == 3 + L);
      e_z  = (m_active && m_age >= 2 + L) ? m_prod : m_zprev;
      check("busy",     64'(bus.busy),  64'(m_active));
      check("lo_wr",    64'(bus.lo_wr), 64'(e_lo));
      check("hi_wr",    64'(bus.hi_wr), 64'(e_hi));
      check("done",     64'(bus.done),  64'(e_hi));
      check("wb_data",  64'(bus.wb_data),
            e_lo ? {32'd0, m_prod[31:0]} : (e_hi ? {32'd0, m_prod[63:32]} : 64'd0));
      check("zlo",      64'(bus.zlo), {32'd0, e_z[31:0]});
      check("zhi",      64'(bus.zhi), {32'd0, e_z[63:32]});
      check("mul_mcnd", 64'(bus.mul_mcnd), 64'(m_a));
      check("mul_mplr", 64'(bus.mul_mplr), 64'(m_b));
   end

   // Drives a request in the current cycle (c0); returns at the negedge of c1.
   task automatic go(input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",    64'(bus.busy),    64'd0);
      check("rst_wb_data", 64'(bus.wb_data), 64'd0);
      check("rst_zlo",     64'(bus.zlo),     64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 7 x 6
      go(32'd7, 32'd6);
      check("p1_busy_c1", 64'(bus.busy), 64'd1);
      repeat (2) @(negedge clk);
      check("p1_lo_wr", 64'(bus.lo_wr), 64'd1);
      check("p1_lo_data", 64'(bus.wb_data), 64'h2A);
      @(negedge clk);
      check("p1_hi_wr", 64'(bus.hi_wr), 64'd1);
      check("p1_done", 64'(bus.done), 64'd1);
      check("p1_hi_data", 64'(bus.wb_data), 64'h0);
      check("p1_zlo", 64'(bus.zlo), 64'd42);
      check("p1_zhi", 64'(bus.zhi), 64'd0);
      @(negedge clk);
      check("p1_idle_c5", 64'(bus.busy), 64'd0);

      // -3 x 5, back to back
      go(32'hFFFF_FFFD, 32'd5);
      repeat (2) @(negedge clk);
      check("p2_lo_data", 64'(bus.wb_data), 64'hFFFF_FFF1);
      @(negedge clk);
      check("p2_hi_data", 64'(bus.wb_data), 64'hFFFF_FFFF);
      check("p2_done", 64'(bus.done), 64'd1);
      @(negedge clk);
      check("p2_done_one_cycle", 64'(bus.done), 64'd0);

      // 0x80000000 squared
      go(32'h8000_0000, 32'h8000_0000);
      repeat (2) @(negedge clk);
      check("p3_lo_wr", 64'(bus.lo_wr), 64'd1);
      check("p3_lo_data", 64'(bus.wb_data), 64'h0);
      check("p3_zhi", 64'(bus.zhi), 64'h4000_0000);
      @(negedge clk);
      check("p3_hi_data", 64'(bus.wb_data), 64'h4000_0000);
      @(negedge clk);

      // start while busy in c2 and c4 must be ignored
      go(32'd7, 32'd6);
      @(negedge clk);
      bus.start = 1'b1; bus.a_in = 32'd9; bus.b_in = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      check("p4_lo_data", 64'(bus.wb_data), 64'h2A);
      check("p4_mcnd_held", 64'(bus.mul_mcnd), 64'd7);
      @(negedge clk);
      bus.start = 1'b1;
      check("p4_hi_done", 64'(bus.done), 64'd1);
      check("p4_zlo", 64'(bus.zlo), 64'd42);
      @(negedge clk);
      check("p4_busy_c5", 64'(bus.busy), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check("p5_lo_wr_c8", 64'(bus.lo_wr), 64'd1);
      check("p5_lo_data_c8", 64'(bus.wb_data), 64'd81);
      repeat (2) @(negedge clk);

      // reset mid-WAIT drops the request
      go(32'd7, 32'd6);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_busy", 64'(bus.busy), 64'd0);
      check("rst_mid_mcnd", 64'(bus.mul_mcnd), 64'd0);
      check("rst_mid_zlo", 64'(bus.zlo), 64'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_strobe", 64'(bus.lo_wr | bus.hi_wr), 64'd0);
      end
      go(32'd7, 32'd6);
      repeat (2) @(negedge clk);
      check("p6_lo_data", 64'(bus.wb_data), 64'h2A);
      @(negedge clk);
      check("p6_done", 64'(bus.done), 64'd1);
      @(negedge clk);

      // idle hold
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_strobes", 64'(bus.lo_wr | bus.hi_wr | bus.busy), 64'd0);
      end
      check("idle_zlo", 64'(bus.zlo), 64'd42);
      check("idle_mcnd", 64'(bus.mul_mcnd), 64'd7);
      check("idle_mplr", 64'(bus.mul_mplr), 64'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mul_hilo_sequencer.md
# mul_hilo_sequencer

Control and writeback stage wrapped around the 32x32 Booth multiplier in the datapath. Accepts a multiply request with two 32-bit signed operands, drives them into the multiplier and holds them stable, and waits out the multiplier's registered latency. It then captures the 64-bit product into internal ZHI/ZLO registers and writes it back over the 32-bit bus as two single-cycle writes, LO first, then HI.

## Interface
- MUL_LATENCY, default 1: cycles from operands registered on mul_mcnd/mul_mplr until mul_y is valid; legal range 1–15.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a_in  in  32  multiplicand, signed two's complement; sampled with start
- b_in  in  32  multiplier, signed two's complement; sampled with start
- mul_mcnd  out  32  operand to multiplier Mcnd
- mul_mplr  out  32  operand to multiplier Mplr
- mul_y  in  64  product from multiplier
- busy  out  1  high in every non-IDLE state
- wb_data  out  32  writeback data; 0 outside WB_LO/WB_HI
- lo_wr  out  1  LO write strobe, one cycle
- hi_wr  out  1  HI write strobe, one cycle
- done  out  1  one-cycle pulse, coincident with hi_wr
- zhi  out  32  captured product bits [63:32]
- zlo  out  32  captured product bits [31:0]

## Operation
- **States:** IDLE, WAIT, WB_LO, WB_HI. Use a state register plus a 4-bit latency counter `cnt`.
- **IDLE:**
  - If start=1 at the clock edge: register a_in→mul_mcnd and b_in→mul_mplr, set cnt=MUL_LATENCY, and go to WAIT.
  - If start=0: stay in IDLE; operands and Z registers hold.
- **WAIT:**
  - At each edge with cnt≠0: decrement cnt.
  - At the edge with cnt==0: zhi←mul_y[63:32], zlo←mul_y[31:0], go to WB_LO.
  - WAIT therefore lasts MUL_LATENCY+1 cycles. The extra cycle covers the multiplier's output register.
- **WB_LO:** lo_wr=1, wb_data=zlo. Next state is WB_HI.
- **WB_HI:** hi_wr=1, wb_data=zhi, done=1. Next state is IDLE.
- **Outputs:** all strobes (lo_wr, hi_wr, done) are decoded from state only.
- **Operand hold:** mul_mcnd and mul_mplr hold from the accepting edge until the next accepted start. This keeps the multiplier's recomputed output stable.
- **No arithmetic:** the block performs none. The product is passed through bit-exact; sign handling belongs to the multiplier.
- **start while busy:** ignored, including in the WB_HI/done cycle. Nothing is queued.
- **Back-to-back requests:** start in the first IDLE cycle after done is accepted normally.
- **Reset, at any time (including mid-WAIT or mid-writeback):**
  - Immediately forces state=IDLE and cnt=0.
  - Forces mul_mcnd, mul_mplr, zhi and zlo to 0.
  - Forces busy, lo_wr, hi_wr, done to 0 and wb_data to 0.
  - A request in flight is dropped, with no partial writeback.

## Timing
- **Reset values:** every output is 0.
- **Cycle numbering:** the cycle in which start is sampled high in IDLE is c0.
  - End of c0: operands registered; busy=1 from c1.
  - End of c(1+MUL_LATENCY): Z registers captured.
  - c(2+MUL_LATENCY): lo_wr=1.
  - c(3+MUL_LATENCY): hi_wr=1, done=1.
  - c(4+MUL_LATENCY): IDLE, busy=0.
- **For MUL_LATENCY=1:**
  - busy is high c1–c4.
  - lo_wr in c3; hi_wr/done in c4.
  - The next start is accepted in c5.
  - Total is 5 cycles per multiply.
- **Write ordering:** exactly one strobe per writeback cycle; lo_wr and hi_wr are never high together.
- **Z register visibility:** zhi/zlo change only at the capture edge (or at reset) and are stable through both writeback cycles.

## Test plan
Bench uses a behavioural multiplier model with registered 64-bit output, latency 1, and MUL_LATENCY=1.
- **Unsigned-range product:** a_in=7, b_in=6, start in c0 → c3: lo_wr=1, wb_data=0x0000002A; c4: hi_wr=1, done=1, wb_data=0x00000000; zlo=42, zhi=0.
- **Negative operand:** a_in=0xFFFFFFFD (−3), b_in=5 → c3: wb_data=0xFFFFFFF1; c4: wb_data=0xFFFFFFFF; done pulse is exactly one cycle.
- **Extreme operands:** a_in=b_in=0x80000000 → zhi=0x40000000, zlo=0x00000000; written LO then HI.
- **Busy blocking:**
  - Start a 7×6 request in c0; assert start with a_in=9, b_in=9 in c2 and c4.
  - Required: both ignored; result written is still 42; busy=0 in c5.
  - start in c5 with 9×9 → lo write of 81 in c8.
- **Reset mid-operation:**
  - Start 7×6, assert reset in c2.
  - Required: all outputs 0 immediately; no lo_wr/hi_wr for the dropped request.
  - After deassert, a new start runs a full 5-cycle sequence.
- **Idle hold:** after a completed 7×6 request, hold start=0 for 10 cycles → busy=0, no strobes, zlo=42, mul_mcnd=7 and mul_mplr=6 held.
